// File: rtl/kuuga_cache_pkg.sv
// Shared types and constants for the cache refill path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package kuuga_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } refill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Clear the byte-offset-within-line bits; line_bytes must be a power of two.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned line_bytes);
        return addr & ~(64'(line_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/cc_line_buffer.sv
// Line assembly register file: one word written per accepted beat, whole line read in parallel.
// Latency: a write is visible on line the cycle after wr_en.
// Backpressure: none; accepts a write every cycle.
module cc_line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 wr_idx,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] line
);

    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] words_q, words_d;

    // Word-indexed write; unwritten words keep the previous line's contents.
    always_comb begin
        words_d = words_q;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (wr_en && wr_idx == IDX_W'(i)) begin
                words_d[i] = wr_data;
            end
        end
    end

    // Storage registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign line = words_q;

endmodule

// File: rtl/cc_line_refill_engine.sv
// AXI4 read-burst refill master: fetches one cache line per miss as an INCR burst (CC_REFILL_PERF_EN adds perf counters).
// Latency: accept -> arvalid 1 cycle, last beat -> resp_valid 1 cycle; accept..resp spans LINE_WORDS+3 cycles best case.
// Backpressure: req_ready only in IDLE; arready stalls and rvalid gaps of any length are absorbed.
module cc_line_refill_engine
    import kuuga_cache_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             resp_valid,
    output logic [ADDR_WIDTH-1:0]            resp_addr,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_line,
    output logic                             resp_err,
    output logic [3:0]                       m_axi_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                       m_axi_rresp,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready
`ifdef CC_REFILL_PERF_EN
    ,
    output logic [31:0]                      perf_refills,
    output logic [31:0]                      perf_stall_cycles,
    output logic [15:0]                      perf_errors
`endif
);

    localparam int         IDX_W      = $clog2(LINE_WORDS);
    localparam int         LINE_BYTES = LINE_WORDS * DATA_WIDTH / 8;
    localparam logic [2:0] AR_SIZE    = 3'($clog2(DATA_WIDTH / 8));

    refill_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [IDX_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic                  beat_fire;
    logic                  last_idx;

    assign beat_fire = (state_q == R) && m_axi_rvalid;
    assign last_idx  = (beat_cnt_q == IDX_W'(LINE_WORDS - 1));

    // Refill FSM: latch the aligned line address, issue AR, collect beats, pulse the response.
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    line_addr_d = ADDR_WIDTH'(line_align(64'(req_addr), LINE_BYTES));
                    err_d       = 1'b0;
                    beat_cnt_d  = '0;
                    state_d     = AR;
                end
            end
            AR: begin
                if (m_axi_arready) begin
                    state_d = R;
                end
            end
            R: begin
                if (m_axi_rvalid) begin
                    beat_cnt_d = beat_cnt_q + IDX_W'(1);
                    // Bad response, or rlast disagreeing with the expected last beat, poisons the line.
                    if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != last_idx) begin
                        err_d = 1'b1;
                    end
                    if (m_axi_rlast || last_idx) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and refill context registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
        end
    end

    cc_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (beat_fire),
        .wr_idx  (beat_cnt_q),
        .wr_data (m_axi_rdata),
        .line    (resp_line)
    );

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_addr     = line_addr_q;
    assign resp_err      = err_q;
    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = line_addr_q;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state_q == AR);
    assign m_axi_rready  = (state_q == R);

`ifdef CC_REFILL_PERF_EN
    logic [31:0] perf_refills_q, perf_refills_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_errors_q, perf_errors_d;

    // Saturating counters: completed refills, AR/R wait cycles, errored refills.
    always_comb begin
        perf_refills_d = perf_refills_q;
        perf_stall_d   = perf_stall_q;
        perf_errors_d  = perf_errors_q;
        if (state_q == RESP && perf_refills_q != '1) begin
            perf_refills_d = perf_refills_q + 32'd1;
        end
        if (((state_q == AR && !m_axi_arready) || (state_q == R && !m_axi_rvalid)) && perf_stall_q != '1) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (state_q == RESP && err_q && perf_errors_q != '1) begin
            perf_errors_d = perf_errors_q + 16'd1;
        end
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_refills_q <= '0;
            perf_stall_q   <= '0;
            perf_errors_q  <= '0;
        end else begin
            perf_refills_q <= perf_refills_d;
            perf_stall_q   <= perf_stall_d;
            perf_errors_q  <= perf_errors_d;
        end
    end

    assign perf_refills      = perf_refills_q;
    assign perf_stall_cycles = perf_stall_q;
    assign perf_errors       = perf_errors_q;
`endif

endmodule

// File: tb/tb_cc_line_refill_engine.sv
// Directed bench for cc_line_refill_engine with a cycle-stepped AXI read slave driven from the stimulus thread.
// Latency: n/a.
// Backpressure: the slave model inserts arready stalls and rvalid gaps on request.
module tb_cc_line_refill_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         resp_valid;
    logic [31:0]  resp_addr;
    logic [127:0] resp_line;
    logic         resp_err;
    logic [3:0]   m_axi_arid;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [31:0]  m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
`ifdef CC_REFILL_PERF_EN
    logic [31:0]  perf_refills;
    logic [31:0]  perf_stall_cycles;
    logic [15:0]  perf_errors;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cc_line_refill_engine #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LINE_WORDS (4),
        .AXI_ID     (4'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_addr     (resp_addr),
        .resp_line     (resp_line),
        .resp_err      (resp_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
`ifdef CC_REFILL_PERF_EN
        ,
        .perf_refills      (perf_refills),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_errors       (perf_errors)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One refill. Memory holds word address i at byte address 4i. Inputs are driven and outputs
    // sampled 1 time unit after each rising edge. lat is the cycle index of resp_valid, counting the
    // accept cycle as 0 (so accept..resp spans lat+1 cycles). rst_beat >= 0 holds req_valid high and
    // asserts rst once that many beats have been accepted; the task then returns with rst pending.
    task automatic refill(input logic [31:0] addr, input int ar_stall, input int gap_beat, input int gap_len,
                          input int err_beat, input int last_beat, input int rst_beat,
                          output int lat, output int beats, output logic addr_ok, output logic busy_ok);
        int ar_wait;
        int gap_cnt;
        int cyc;
        logic [31:0] base;
        ar_wait = 0;
        gap_cnt = 0;
        base    = addr & ~32'hF;
        lat     = -1;
        beats   = 0;
        addr_ok = 1'b1;
        busy_ok = 1'b1;
        check("req_ready_before_req", 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk); #1;
        if (rst_beat < 0) req_valid = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            m_axi_arready = m_axi_arvalid && (ar_wait >= ar_stall);
            if (m_axi_arvalid) begin
                if (m_axi_araddr !== base) addr_ok = 1'b0;
                ar_wait++;
            end
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
            m_axi_rdata  = '0;
            if (m_axi_rready) begin
                if (beats == rst_beat) begin
                    rst       = 1'b1;
                    req_valid = 1'b0;
                    lat       = -2;
                    break;
                end
                if (beats == gap_beat && gap_cnt < gap_len) begin
                    gap_cnt++;
                end else begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = (base >> 2) + 32'(beats);
                    m_axi_rresp  = (beats == err_beat) ? 2'b10 : 2'b00;
                    m_axi_rlast  = (beats == last_beat);
                end
            end
            if (req_ready) busy_ok = 1'b0;
            if (resp_valid) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
            if (m_axi_rvalid) beats++;
            cyc++;
        end
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;
    endtask

    int   lat, lat_stall, beats;
    logic addr_ok, busy_ok;
    logic [127:0] line_hold;

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        m_axi_arready = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state and constant AR fields.
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_resp_err", 128'(resp_err), 128'(0));
        check("rst_arvalid", 128'(m_axi_arvalid), 128'(0));
        check("rst_rready", 128'(m_axi_rready), 128'(0));
        check("rst_resp_line", resp_line, 128'(0));
        check("rst_resp_addr", 128'(resp_addr), 128'(0));
        check("arid", 128'(m_axi_arid), 128'(0));
        check("arlen", 128'(m_axi_arlen), 128'(3));
        check("arsize", 128'(m_axi_arsize), 128'(2));
        check("arburst", 128'(m_axi_arburst), 128'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        // Stray beat while idle is not taken.
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hDEAD_BEEF;
        check("stray_rready", 128'(m_axi_rready), 128'(0));
        @(posedge clk); #1;
        m_axi_rvalid = 1'b0;
        check("stray_resp_valid", 128'(resp_valid), 128'(0));
        check("stray_line", resp_line, 128'(0));

        // Stalls: arready low 5 cycles, 2-cycle gap before beat 2. Expected 6 + 5 + 2 = 13.
        refill(32'h0000_0104, 5, 2, 2, -1, 3, -1, lat_stall, beats, addr_ok, busy_ok);
        check("stall_lat", 128'(lat_stall), 128'(13));
        check("stall_araddr_stable", 128'(addr_ok), 128'(1));
        check("stall_line", resp_line, 128'h00000043_00000042_00000041_00000040);
        check("stall_err", 128'(resp_err), 128'(0));
        check("stall_resp_addr", 128'(resp_addr), 128'h100);
        check("stall_busy", 128'(busy_ok), 128'(1));
        @(posedge clk); #1;

        // Error response on beat 2; line base 0x130 holds words 0x4C..0x4F.
        refill(32'h0000_013C, 0, -1, 0, 2, 3, -1, lat, beats, addr_ok, busy_ok);
        check("err_beats", 128'(beats), 128'(4));
        check("err_flag", 128'(resp_err), 128'(1));
        check("err_lat", 128'(lat), 128'(6));
        check("err_line", resp_line, 128'h0000004F_0000004E_0000004D_0000004C);
        @(posedge clk); #1;

`ifdef CC_REFILL_PERF_EN
        check("perf_refills", 128'(perf_refills), 128'(2));
        check("perf_stall_cycles", 128'(perf_stall_cycles), 128'(7));
        check("perf_errors", 128'(perf_errors), 128'(1));
`endif

        // Single refill, no stalls: accept..resp spans LINE_WORDS+3 = 7 cycles.
        refill(32'h0000_0104, 0, -1, 0, -1, 3, -1, lat, beats, addr_ok, busy_ok);
        check("single_span", 128'(lat + 1), 128'(7));
        check("single_araddr", 128'(addr_ok), 128'(1));
        check("single_line", resp_line, 128'h00000043_00000042_00000041_00000040);
        check("single_err", 128'(resp_err), 128'(0));
        check("single_resp_addr", 128'(resp_addr), 128'h100);
        check("stall_delta", 128'(lat_stall - lat), 128'(7));
        line_hold = resp_line;
        @(posedge clk); #1;
        check("resp_pulse_one_cycle", 128'(resp_valid), 128'(0));
        check("req_ready_after_resp", 128'(req_ready), 128'(1));
        check("line_hold", resp_line, line_hold);
        check("addr_hold", 128'(resp_addr), 128'h100);

        // Early rlast on beat 1.
        refill(32'h0000_0008, 0, -1, 0, -1, 1, -1, lat, beats, addr_ok, busy_ok);
        check("early_beats", 128'(beats), 128'(2));
        check("early_lat", 128'(lat), 128'(4));
        check("early_err", 128'(resp_err), 128'(1));
        check("early_low_words", 128'(resp_line[63:0]), 128'h00000001_00000000);
        @(posedge clk); #1;

        // Next request after the framing error proceeds normally.
        refill(32'h0000_01F4, 0, -1, 0, -1, 3, -1, lat, beats, addr_ok, busy_ok);
        check("post_early_lat", 128'(lat), 128'(6));
        check("post_early_err", 128'(resp_err), 128'(0));
        check("post_early_line", resp_line, 128'h0000007F_0000007E_0000007D_0000007C);
        @(posedge clk); #1;

        // Overlapping request held high, then reset in R after beat 1.
        refill(32'h0000_0300, 0, -1, 0, -1, 3, 2, lat, beats, addr_ok, busy_ok);
        check("ovl_reached_reset", 128'(lat), 128'(-2));
        check("ovl_busy_req_ready", 128'(busy_ok), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        check("ovl_rst_arvalid", 128'(m_axi_arvalid), 128'(0));
        check("ovl_rst_rready", 128'(m_axi_rready), 128'(0));
        check("ovl_rst_req_ready", 128'(req_ready), 128'(1));
        check("ovl_rst_resp_valid", 128'(resp_valid), 128'(0));
        check("ovl_rst_line", resp_line, 128'(0));

        // Fresh refill after reset.
        refill(32'h0000_0200, 0, -1, 0, -1, 3, -1, lat, beats, addr_ok, busy_ok);
        check("fresh_lat", 128'(lat), 128'(6));
        check("fresh_line", resp_line, 128'h00000083_00000082_00000081_00000080);
        check("fresh_err", 128'(resp_err), 128'(0));
        check("fresh_resp_addr", 128'(resp_addr), 128'h200);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
